// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin controller for a byte-addressed,
// little-endian data memory with combinational 32-bit read and synchronous
// 4-byte write. Sub-word stores are performed as read-modify-write.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req_*                   per-requester request (index 0 = MEM stage,
//                             index 1 = loader/debug), accepted on valid&ready
//   o_req_ready               one-hot grant, combinational, IDLE only
//   o_rsp_valid/err/rdata     one-cycle response to the owning requester
//   o_mem_*, i_mem_rdata      attached memory interface
//
// Optional: define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with an error response.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES  = 129,
  parameter bit          RESET_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [1:0]  i_req_write,
  input  logic [3:0]  i_req_size,
  input  logic [1:0]  i_req_unsigned,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  output logic [1:0]  o_rsp_valid,
  output logic        o_rsp_err,
  output logic [31:0] o_rsp_rdata,
  output logic        o_mem_clk_enable,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;      // owner granted most recently
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;

  logic [1:0]  grant;
  logic        sel;
  logic        sel_wr;
  logic [1:0]  sel_size;
  logic        sel_uns;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic [32:0] end_addr;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Grant: single valid wins outright; on a tie the requester not granted
  // last time wins.
  always_comb begin
    grant = '0;
    if (state_q == IDLE) begin
      unique case (i_req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  assign o_req_ready = grant;
  assign sel         = grant[1];

  always_comb begin
    sel_wr    = sel ? i_req_write[1]     : i_req_write[0];
    sel_size  = sel ? i_req_size[3:2]    : i_req_size[1:0];
    sel_uns   = sel ? i_req_unsigned[1]  : i_req_unsigned[0];
    sel_addr  = sel ? i_req_addr[63:32]  : i_req_addr[31:0];
    sel_wdata = sel ? i_req_wdata[63:32] : i_req_wdata[31:0];
    // 33-bit sum so addresses near 2^32 cannot wrap into range
    end_addr  = {1'b0, sel_addr} + 33'd4;
    sel_err   = (sel_size == 2'b11) || (end_addr > 33'(MEM_BYTES));
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((sel_size == 2'b01 && sel_addr[0]) ||
        (sel_size == 2'b10 && sel_addr[1:0] != 2'b00)) begin
      sel_err = 1'b1;
    end
`endif
  end

  // Memory returns addr..addr+3, so the addressed byte is always in [7:0].
  always_comb begin
    load_ext = i_mem_rdata;
    merged   = i_mem_rdata;
    if (size_q == 2'b00) begin
      load_ext = {{24{~uns_q & i_mem_rdata[7]}}, i_mem_rdata[7:0]};
      merged   = {i_mem_rdata[31:8], wdata_q[7:0]};
    end else if (size_q == 2'b01) begin
      load_ext = {{16{~uns_q & i_mem_rdata[15]}}, i_mem_rdata[15:0]};
      merged   = {i_mem_rdata[31:16], wdata_q[15:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          owner_d = sel;
          wr_d    = sel_wr;
          size_d  = sel_size;
          uns_d   = sel_uns;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = sel_err;
          rdata_d = '0;
          state_d = sel_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!wr_q) begin
          rdata_d = load_ext;
          state_d = RESP;
        end else if (size_q == 2'b10) begin
          state_d = RESP;
        end else begin
          merge_d = merged;
          state_d = RMW_WR;
        end
      end
      RMW_WR: state_d = RESP;
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      last_q  <= ~RESET_PRIO;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end

  // Outputs decode from state only, so reset drops the write strobe at once.
  always_comb begin
    o_rsp_valid      = '0;
    o_rsp_err        = 1'b0;
    o_rsp_rdata      = '0;
    o_mem_clk_enable = 1'b0;
    o_mem_write      = 1'b0;
    o_mem_addr       = '0;
    o_mem_wdata      = '0;
    unique case (state_q)
      ACCESS: begin
        o_mem_clk_enable = 1'b1;
        o_mem_addr       = addr_q;
        if (wr_q && size_q == 2'b10) begin
          o_mem_write = 1'b1;
          o_mem_wdata = wdata_q;
        end
      end
      RMW_WR: begin
        o_mem_clk_enable = 1'b1;
        o_mem_write      = 1'b1;
        o_mem_addr       = addr_q;
        o_mem_wdata      = merge_q;
      end
      RESP: begin
        o_rsp_valid[owner_q] = 1'b1;
        o_rsp_err            = err_q;
        o_rsp_rdata          = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned MEMB = 129;
  localparam bit          PRIO = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  i_req_valid = '0;
  logic [1:0]  o_req_ready;
  logic [1:0]  i_req_write = '0;
  logic [3:0]  i_req_size = '0;
  logic [1:0]  i_req_unsigned = '0;
  logic [63:0] i_req_addr = '0;
  logic [63:0] i_req_wdata = '0;
  logic [1:0]  o_rsp_valid;
  logic        o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic        o_mem_clk_enable;
  logic        o_mem_write;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [0:MEMB-1];
  logic        mem_init = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEMB), .RESET_PRIO(PRIO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err), .o_rsp_rdata(o_rsp_rdata),
    .o_mem_clk_enable(o_mem_clk_enable), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Memory model: combinational read of 4 bytes, synchronous 4-byte write.
  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (({1'b0, o_mem_addr} + 33'(k)) < 33'(MEMB))
        mem_rdata[8*k +: 8] = mem[o_mem_addr + 32'(k)];
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(MEMB); i++) mem[i] <= 8'(i);
    end else if (o_mem_clk_enable && o_mem_write) begin
      for (int k = 0; k < 4; k++) begin
        if (({1'b0, o_mem_addr} + 33'(k)) < 33'(MEMB))
          mem[o_mem_addr + 32'(k)] <= o_mem_wdata[8*k +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic drive(input vec_t v);
    i_req_valid    = v.req ? 2'b10 : 2'b01;
    i_req_write    = v.req ? {v.wr, 1'b0} : {1'b0, v.wr};
    i_req_size     = v.req ? {v.size, 2'b00} : {2'b00, v.size};
    i_req_unsigned = v.req ? {v.uns, 1'b0} : {1'b0, v.uns};
    i_req_addr     = v.req ? {v.addr, 32'h0} : {32'h0, v.addr};
    i_req_wdata    = v.req ? {v.wdata, 32'h0} : {32'h0, v.wdata};
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit got;
    int memact, wrcnt;
    logic [1:0] exp_ready;
    got = 0; memact = 0; wrcnt = 0;
    exp_ready = v.req ? 2'b10 : 2'b01;
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("v%0d_ready", idx), 32'(o_req_ready), 32'(exp_ready));
    @(posedge clk);
    @(negedge clk);
    i_req_valid = '0;
    for (int c = 1; c <= 6 && !got; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (o_mem_clk_enable) memact++;
      if (o_mem_write) wrcnt++;
      if (o_rsp_valid != 2'b00) begin
        got = 1;
        chk($sformatf("v%0d_latency", idx), 32'(c), 32'(v.exp_lat));
        chk($sformatf("v%0d_rsp_owner", idx), 32'(o_rsp_valid), 32'(exp_ready));
        chk($sformatf("v%0d_err", idx), 32'(o_rsp_err), 32'(v.exp_err));
        chk($sformatf("v%0d_rdata", idx), o_rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_ready_busy", idx), 32'(o_req_ready), 32'd0);
      end
    end
    chk($sformatf("v%0d_rsp_seen", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d_mem_writes", idx), 32'(wrcnt), (v.wr && !v.exp_err) ? 32'd1 : 32'd0);
    if (v.exp_err) chk($sformatf("v%0d_no_mem_activity", idx), 32'(memact), 32'd0);
  endtask

  vec_t vecs [23];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ng, last_t;
    logic pend_owner, exp_g;
    logic [31:0] exp_rd;

    // Table: req, wr, size, uns, addr, wdata, exp_err, exp_rdata, exp_lat
    vecs[0]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        1'b0, 32'h03020100, 2};
    vecs[1]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h05, 32'h123456AB, 1'b0, 32'h0,        3};
    vecs[2]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        1'b0, 32'h0706AB04, 2};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h04, 32'h00000084, 1'b0, 32'h0,        3};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h04, 32'h0,        1'b0, 32'hFFFFFF84, 2};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h04, 32'h0,        1'b0, 32'h00000084, 2};
    vecs[6]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        1'b0, 32'h0706AB84, 2};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[7]  = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h09, 32'h1234BEEF, 1'b1, 32'h0,        1};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        1'b0, 32'h0B0A0908, 2};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h09, 32'h0,        1'b1, 32'h0,        1};
    vecs[10] = '{1'b0, 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0,        1'b0, 32'h00000B0A, 2};
    vecs[13] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0,        1'b1, 32'h0,        1};
`else
    vecs[7]  = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h09, 32'h1234BEEF, 1'b0, 32'h0,        3};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        1'b0, 32'h0BBEEF08, 2};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h09, 32'h0,        1'b0, 32'hFFFFBEEF, 2};
    vecs[10] = '{1'b0, 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0,        1'b0, 32'h00000BBE, 2};
    vecs[13] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0,        1'b0, 32'h24232221, 2};
`endif
    vecs[11] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        2};
    vecs[12] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2};
    vecs[14] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0,        1'b0, 32'h7F7E7D7C, 2};
    vecs[15] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h7E, 32'h0,        1'b1, 32'h0,        1};
    vecs[16] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h80, 32'h0,        1'b1, 32'h0,        1};
    vecs[17] = '{1'b0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        1'b1, 32'h0,        1};
    vecs[18] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h80, 32'hFFFFFFFF, 1'b1, 32'h0,        1};
    vecs[19] = '{1'b0, 1'b0, 2'b00, 1'b1, 32'h7D, 32'h0,        1'b0, 32'h0000007D, 2};
    vecs[20] = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0,        1'b0, 32'h00002120, 2};
    vecs[21] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0,  1'b1, 32'h0,        1};
    vecs[22] = '{1'b1, 1'b1, 2'b11, 1'b0, 32'h40, 32'h55555555, 1'b1, 32'h0,        1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(o_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("rst_mem_en", 32'(o_mem_clk_enable), 32'd0);
    chk("rst_mem_write", 32'(o_mem_write), 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    mem_init = 1'b0;
    rst_n = 1'b1;

    // Round robin with both requesters valid continuously
    @(negedge clk);
    i_req_valid = 2'b11; i_req_write = '0; i_req_size = 4'b1010; i_req_unsigned = '0;
    i_req_addr = {32'h4, 32'h0}; i_req_wdata = '0;
    ng = 0; last_t = 0; pend_owner = 1'b0; exp_g = PRIO;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      #1;
      if (o_rsp_valid != 2'b00) begin
        exp_rd = pend_owner ? 32'h07060504 : 32'h03020100;
        chk("rr_rsp_owner", 32'(o_rsp_valid), pend_owner ? 32'd2 : 32'd1);
        chk("rr_rsp_rdata", o_rsp_rdata, exp_rd);
      end
      if (o_req_ready != 2'b00) begin
        chk("rr_grant", 32'(o_req_ready), exp_g ? 32'd2 : 32'd1);
        if (ng > 0) chk("rr_gap", 32'(cyc - last_t), 32'd3);
        last_t = cyc;
        pend_owner = o_req_ready[1];
        exp_g = ~exp_g;
        ng++;
      end
      @(negedge clk);
    end
    chk("rr_grant_count", 32'(ng), 32'd4);
    i_req_valid = '0;
    repeat (3) @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 23; i++) run_vec(i, vecs[i]);
    chk("err_store_untouched", {24'h0, mem[128]}, 32'h00000080);

    // Reset during RMW_WR of a byte store
    @(negedge clk);
    i_req_valid = 2'b10; i_req_write = 2'b10; i_req_size = 4'b0000; i_req_unsigned = '0;
    i_req_addr = {32'h30, 32'h0}; i_req_wdata = {32'h00000055, 32'h0};
    #1;
    chk("rmwrst_ready", 32'(o_req_ready), 32'd2);
    @(posedge clk);
    @(negedge clk);
    i_req_valid = '0;
    #1;
    chk("rmwrst_access_read", {30'h0, o_mem_clk_enable, o_mem_write}, 32'd2);
    @(negedge clk);
    #1;
    chk("rmwrst_rmw_strobe", 32'(o_mem_write), 32'd1);
    chk("rmwrst_rmw_wdata", o_mem_wdata, 32'h33323155);
    rst_n = 1'b0;
    #1;
    chk("rmwrst_write_drop", 32'(o_mem_write), 32'd0);
    chk("rmwrst_no_rsp", 32'(o_rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rmwrst_mem_unchanged", {mem[51], mem[50], mem[49], mem[48]}, 32'h33323130);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rmwrst_post_no_rsp", 32'(o_rsp_valid), 32'd0);
      chk("rmwrst_post_idle", 32'(o_mem_clk_enable), 32'd0);
    end
    run_vec(99, '{1'b0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'h33323130, 2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller for the pipeline's byte-addressed, little-endian data memory. The memory has a combinational 32-bit read and a synchronous 4-byte write.
- Requester 0 is the pipeline MEM stage. Requester 1 is the loader/debug port.
- Round-robin arbitration, one outstanding transaction at a time.
- Supports byte, halfword and word accesses. Sub-word stores use an internal read-modify-write, since the memory always writes 4 bytes.

Parameters:
- MEM_BYTES, 129, number of addressable bytes in the attached memory; every access touches addr..addr+3.
- RESET_PRIO, 0, requester given priority on the first tie after reset.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  2  per-requester request valid
- o_req_ready  out  2  per-requester accept; a request is taken when valid&ready
- i_req_write  in  2  per-requester 1=store, 0=load
- i_req_size  in  4  2 bits per requester: 00 byte, 01 half, 10 word, 11 illegal
- i_req_unsigned  in  2  per-requester zero-extend (1) / sign-extend (0) sub-word loads
- i_req_addr  in  64  32-bit byte address per requester; [31:0]=req0
- i_req_wdata  in  64  32-bit store data per requester, right-aligned
- o_rsp_valid  out  2  one-cycle response pulse to the owning requester
- o_rsp_err  out  1  qualifies o_rsp_valid; 1=access rejected, no memory effect
- o_rsp_rdata  out  32  load result, extended; 0 for stores and errors
- o_mem_clk_enable  out  1  memory clock enable
- o_mem_write  out  1  memory write strobe
- o_mem_addr  out  32  memory byte address
- o_mem_wdata  out  32  memory write data
- i_mem_rdata  in  32  memory combinational read data

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Round-robin pointer set so RESET_PRIO wins the first tie.
  - Latched request cleared.
- FSM states: IDLE, ACCESS, RMW_WR, RESP.
- IDLE:
  - o_req_ready = 1 for the grant winner only, combinationally, when any valid is high.
  - Single valid: that requester wins.
  - Both valid: the requester not granted last time wins.
  - On accept, latch write/size/unsigned/addr/wdata/owner.
  - Error check at accept: size=11, or addr+4 > MEM_BYTES (computed in 33 bits, no wrap). On error go to RESP with err flag set; there is no memory access.
  - Otherwise go to ACCESS.
- ACCESS:
  - o_mem_addr = latched addr; o_mem_clk_enable = 1.
  - Load: capture i_mem_rdata, extract bytes [7:0] (byte) or [15:0] (half), extend per the unsigned flag, go to RESP.
  - Word store: o_mem_write = 1, o_mem_wdata = wdata, go to RESP.
  - Sub-word store: capture i_mem_rdata and merge wdata's low 1 or 2 bytes into it, go to RMW_WR.
- RMW_WR: o_mem_write = 1, o_mem_clk_enable = 1, o_mem_wdata = merged word, go to RESP.
- RESP:
  - o_rsp_valid[owner] = 1 for exactly one cycle with err and rdata.
  - Update the round-robin pointer to the owner.
  - Go to IDLE.
- Memory outputs are 0 outside ACCESS/RMW_WR.
- Latency from accept cycle T:
  - Loads and word stores respond at T+2.
  - Sub-word stores respond at T+3.
  - Errors respond at T+1.
- Throughput: at most one accept per 3 cycles (4 for RMW); o_req_ready = 0 in every non-IDLE state.
- Requesters must hold request fields stable while valid&!ready. The block latches fields, so changes after accept are ignored.
- A new request may be accepted in the IDLE cycle directly following RESP.
- Reset asserted mid-transaction: return to IDLE immediately.
  - o_mem_write drops asynchronously, so no partial or RMW write completes.
  - No response is issued; the pending request is discarded.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: at accept, half at an odd addr, or word with addr[1:0] != 0, gets an error response at T+1 with no memory access.
- Undefined: unaligned accesses are performed as ordinary byte-addressed accesses, which the memory supports natively.

Test Plan:
- Only req0 valid, word load at addr 0x00 with memory 00,01,02,03 -> ready at T, rsp_valid[0] at T+2, rdata 0x03020100, err 0.
- req0 byte store 0xAB at addr 0x05 over word 0x07060504 -> read in ACCESS, write 0x0706AB04 in RMW_WR, rsp at T+3; word load at 0x04 returns 0x0706AB04.
- Signed byte load at addr 0x04 of 0x84 -> rdata 0xFFFFFF84; same load with unsigned=1 -> 0x00000084.
- Both requesters valid continuously -> grants alternate 0,1,0,1 starting with RESET_PRIO; no requester is granted twice in a row.
- Word load at addr 126 with MEM_BYTES=129 -> err=1 at T+1 with no mem activity. Size=11 at addr 0 -> err=1.
- Reset during RMW_WR of a byte store -> o_mem_write low, no rsp, memory unchanged, block in IDLE with ready available after release.
